// File: rtl/viterbi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
// Shared definitions for the Viterbi decoder controller: the frame-length
// default and the controller FSM state encoding.
// -----------------------------------------------------------------------------
package viterbi_pkg;

   // Trellis stages per frame unless the instantiating design overrides it.
   localparam int unsigned FRAME_LEN_DEF = 256;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACS,
      ST_FLUSH,
      ST_TB,
      ST_DONE
   } state_t;

endpackage

// File: rtl/viterbi_ctrl_if.sv
// -----------------------------------------------------------------------------
// viterbi_ctrl_if
// Bundles the symbol handshake and the datapath control strobes of
// viterbi_ctrl.
//   master : symbol source / observer (drives in_valid, rx_pair)
//   slave  : the controller (drives in_ready and all control strobes)
// Signals: in_valid, rx_pair[1:0], in_ready, rx_pair_q[1:0], acs_en,
//          acs_init, mem_we, mem_addr[ADDR_W-1:0], tb_en, tb_start,
//          frame_done, busy.
// -----------------------------------------------------------------------------
interface viterbi_ctrl_if
   import viterbi_pkg::*;
#(
   parameter int ADDR_W = $clog2(FRAME_LEN_DEF)
);
   logic              in_valid;
   logic [1:0]        rx_pair;
   logic              in_ready;
   logic [1:0]        rx_pair_q;
   logic              acs_en;
   logic              acs_init;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic              tb_en;
   logic              tb_start;
   logic              frame_done;
   logic              busy;

   modport master (
      output in_valid, rx_pair,
      input  in_ready, rx_pair_q, acs_en, acs_init, mem_we, mem_addr,
             tb_en, tb_start, frame_done, busy
   );

   modport slave (
      input  in_valid, rx_pair,
      output in_ready, rx_pair_q, acs_en, acs_init, mem_we, mem_addr,
             tb_en, tb_start, frame_done, busy
   );
endinterface

// File: rtl/viterbi_addr_cnt.sv
// -----------------------------------------------------------------------------
// viterbi_addr_cnt
// Up/down stage-address counter shared by the forward (ACS) pass and the
// traceback pass. Priority: load > inc > dec. Wraps modulo 2**ADDR_W.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears to 0)
//   load, load_val    synchronous load
//   inc, dec          count up / count down
//   cnt               current count
//   tc_hi, tc_lo      terminal counts: cnt is all-ones / cnt is zero
// -----------------------------------------------------------------------------
module viterbi_addr_cnt #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   input  logic              dec,
   output logic [ADDR_W-1:0] cnt,
   output logic              tc_hi,
   output logic              tc_lo
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       cnt <= '0;
      else if (load) cnt <= load_val;
      else if (inc)  cnt <= cnt + ADDR_W'(1);
      else if (dec)  cnt <= cnt - ADDR_W'(1);
   end

   // FRAME_LEN is a power of two, so the last stage is the all-ones address.
   assign tc_hi = &cnt;
   assign tc_lo = ~|cnt;

endmodule

// File: rtl/viterbi_ctrl.sv
// -----------------------------------------------------------------------------
// viterbi_ctrl
// Frame controller for a Viterbi decoder: accepts FRAME_LEN symbol pairs,
// sequences the ACS stages and survivor-memory writes, then runs a
// FRAME_LEN-cycle traceback reading the survivor memory backwards.
// Ports:
//   clk    sole clock, rising edge
//   rst    asynchronous active-high reset
//   abort  (only with `define VITERBI_CTRL_ABORT_EN) synchronous frame abort
//   bus    viterbi_ctrl_if.slave: handshake in, control strobes out
// All outputs except bus.in_ready are registered.
// -----------------------------------------------------------------------------
module viterbi_ctrl
   import viterbi_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
   input  logic          clk,
   input  logic          rst,
`ifdef VITERBI_CTRL_ABORT_EN
   input  logic          abort,
`endif
   viterbi_ctrl_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

   state_t            state, state_n;
   logic              abort_req, accept;
   logic              acs_en_q, acs_init_q, mem_we_q, tb_en_q, tb_start_q;
   logic              frame_done_q, busy_q;
   logic              acs_en_n, acs_init_n, mem_we_n, tb_en_n, tb_start_n;
   logic              frame_done_n;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
   logic [1:0]        rx_pair_q, rx_pair_n;
   logic              cnt_load, cnt_inc, cnt_dec, tc_hi, tc_lo;
   logic [ADDR_W-1:0] cnt_load_val, cnt;

`ifdef VITERBI_CTRL_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // The counter holds the index of the next stage during the forward pass
   // and the current read address during traceback.
   viterbi_addr_cnt #(.ADDR_W(ADDR_W)) u_addr_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .inc      (cnt_inc),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .tc_hi    (tc_hi),
      .tc_lo    (tc_lo)
   );

   assign bus.in_ready = ((state == ST_IDLE) || (state == ST_ACS)) && !abort_req;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // so no path leaves a signal unassigned and no latch is inferred.
      state_n      = state;
      acs_en_n     = 1'b0;
      acs_init_n   = 1'b0;
      mem_we_n     = 1'b0;
      tb_en_n      = 1'b0;
      tb_start_n   = 1'b0;
      frame_done_n = 1'b0;
      mem_addr_n   = mem_addr_q;
      rx_pair_n    = rx_pair_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_inc      = 1'b0;
      cnt_dec      = 1'b0;

      if (abort_req) begin
         state_n    = ST_IDLE;
         mem_addr_n = '0;
         cnt_load   = 1'b1;
      end else begin
         unique case (state)
            ST_IDLE, ST_ACS: begin
               if (accept) begin
                  acs_en_n   = 1'b1;
                  mem_we_n   = 1'b1;
                  mem_addr_n = cnt;
                  acs_init_n = tc_lo;
                  rx_pair_n  = bus.rx_pair;
                  cnt_inc    = 1'b1;
                  // Stage FRAME_LEN-1 wraps the counter back to 0.
                  state_n    = tc_hi ? ST_FLUSH : ST_ACS;
               end
            end
            ST_FLUSH: begin
               state_n      = ST_TB;
               tb_en_n      = 1'b1;
               tb_start_n   = 1'b1;
               mem_addr_n   = LAST_ADDR;
               cnt_load     = 1'b1;
               cnt_load_val = LAST_ADDR;
            end
            ST_TB: begin
               if (tc_lo) begin
                  state_n      = ST_DONE;
                  frame_done_n = 1'b1;
               end else begin
                  tb_en_n    = 1'b1;
                  mem_addr_n = cnt - ADDR_W'(1);
                  cnt_dec    = 1'b1;
               end
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         acs_en_q     <= 1'b0;
         acs_init_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         tb_en_q      <= 1'b0;
         tb_start_q   <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         mem_addr_q   <= '0;
         rx_pair_q    <= '0;
      end else begin
         state        <= state_n;
         acs_en_q     <= acs_en_n;
         acs_init_q   <= acs_init_n;
         mem_we_q     <= mem_we_n;
         tb_en_q      <= tb_en_n;
         tb_start_q   <= tb_start_n;
         frame_done_q <= frame_done_n;
         busy_q       <= (state_n != ST_IDLE);
         mem_addr_q   <= mem_addr_n;
         rx_pair_q    <= rx_pair_n;
      end
   end

   assign bus.acs_en     = acs_en_q;
   assign bus.acs_init   = acs_init_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.tb_en      = tb_en_q;
   assign bus.tb_start   = tb_start_q;
   assign bus.frame_done = frame_done_q;
   assign bus.busy       = busy_q;
   assign bus.rx_pair_q  = rx_pair_q;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// -----------------------------------------------------------------------------
// tb_viterbi_ctrl
// Self-checking bench for viterbi_ctrl with FRAME_LEN=4. A frame-level
// reference model (accept count plus cycles elapsed since the last accept)
// predicts every output each cycle. Define VITERBI_CTRL_ABORT_EN to also
// exercise the abort port.
// -----------------------------------------------------------------------------
module tb_viterbi_ctrl;

   localparam int F  = 4;
   localparam int AW = $clog2(F);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic abort = 1'b0;

   int checks = 0;
   int errors = 0;

   viterbi_ctrl_if #(.ADDR_W(AW)) bus ();

   viterbi_ctrl #(.FRAME_LEN(F)) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef VITERBI_CTRL_ABORT_EN
      .abort (abort),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: accepts in the current frame, and cycles since
   // the final accept (1 = flush, 2..F+1 = traceback, F+2 = done).
   int          n_acc, t_after;
   logic        e_acs_en, e_acs_init, e_mem_we, e_tb_en, e_tb_start;
   logic        e_frame_done, e_busy;
   logic [AW-1:0] e_addr;
   logic [1:0]  e_rx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      n_acc = 0; t_after = 0;
      e_acs_en = 0; e_acs_init = 0; e_mem_we = 0; e_tb_en = 0; e_tb_start = 0;
      e_frame_done = 0; e_busy = 0; e_addr = '0; e_rx = '0;
   endtask

   task automatic model_step(input logic acc, input logic ab, input logic [1:0] sym);
      e_acs_en = 0; e_acs_init = 0; e_mem_we = 0; e_tb_en = 0; e_tb_start = 0;
      e_frame_done = 0;
      if (ab) begin
         n_acc = 0; t_after = 0; e_addr = '0;
      end else if (n_acc == F) begin
         if (t_after == F + 2) begin
            n_acc = 0; t_after = 0;
         end else begin
            t_after++;
            if (t_after == F + 2) e_frame_done = 1;
            else begin
               e_tb_en    = 1;
               e_addr     = AW'(F + 1 - t_after);
               e_tb_start = (t_after == 2);
            end
         end
      end else if (acc) begin
         e_acs_en   = 1;
         e_mem_we   = 1;
         e_addr     = AW'(n_acc);
         e_acs_init = (n_acc == 0);
         e_rx       = sym;
         n_acc++;
         if (n_acc == F) t_after = 1;
      end
      e_busy = (n_acc != 0);
   endtask

   task automatic check_outputs();
      check("acs_en",     bus.acs_en,     e_acs_en);
      check("acs_init",   bus.acs_init,   e_acs_init);
      check("mem_we",     bus.mem_we,     e_mem_we);
      check("mem_addr",   bus.mem_addr,   e_addr);
      check("tb_en",      bus.tb_en,      e_tb_en);
      check("tb_start",   bus.tb_start,   e_tb_start);
      check("frame_done", bus.frame_done, e_frame_done);
      check("busy",       bus.busy,       e_busy);
      check("rx_pair_q",  bus.rx_pair_q,  e_rx);
   endtask

   // One clock cycle; starts and ends just after a falling edge.
   task automatic cycle(input logic v, input logic [1:0] sym, input logic ab);
      logic exp_ready, acc;
      bus.in_valid = v;
      bus.rx_pair  = sym;
      abort        = ab;
      #1;
      exp_ready = (n_acc < F) && !ab;
      check("in_ready", bus.in_ready, exp_ready);
      acc = v && exp_ready;
      @(posedge clk);
      #1;
      model_step(acc, ab, sym);
      check_outputs();
      @(negedge clk);
   endtask

   // Reset asserted mid-cycle, away from any clock edge.
   task automatic async_reset();
      bus.in_valid = 1'b0;
      abort        = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      check("in_ready_rst", bus.in_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic found;
      bus.in_valid = 1'b0;
      bus.rx_pair  = 2'b00;
      model_reset();

      // Reset state.
      @(negedge clk);
      check_outputs();
      check("in_ready_rst", bus.in_ready, 1'b1);
      rst = 1'b0;

      // Continuous valid: one frame plus idle return.
      for (int i = 0; i < 11; i++) cycle(1'b1, 2'($urandom), 1'b0);
      for (int i = 0; i < 2; i++)  cycle(1'b0, 2'($urandom), 1'b0);

      // Alternating valid.
      for (int i = 0; i < 16; i++) cycle(i[0] == 1'b0, 2'($urandom), 1'b0);

      // Valid held high across back-to-back frames.
      for (int i = 0; i < 24; i++) cycle(1'b1, 2'($urandom), 1'b0);

      // Random valid pattern over several frames.
      for (int i = 0; i < 150; i++) cycle(($urandom_range(0, 3) != 0), 2'($urandom), 1'b0);

      // Reset during traceback at mem_addr 2, then a clean frame.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle(1'b1, 2'($urandom), 1'b0);
         if (e_tb_en && e_addr == AW'(2)) found = 1'b1;
      end
      check("reach_tb_addr2", found, 1'b1);
      async_reset();
      for (int i = 0; i < 12; i++) cycle(1'b1, 2'($urandom), 1'b0);

`ifdef VITERBI_CTRL_ABORT_EN
      // Abort offered with symbol k=2, then a normal frame.
      while (n_acc != 0) cycle(1'b0, 2'($urandom), 1'b0);
      cycle(1'b1, 2'($urandom), 1'b0);
      cycle(1'b1, 2'($urandom), 1'b0);
      cycle(1'b1, 2'($urandom), 1'b1);
      check("abort_idle", bus.busy, 1'b0);
      for (int i = 0; i < 12; i++) cycle(1'b1, 2'($urandom), 1'b0);
      // Random aborts.
      for (int i = 0; i < 120; i++)
         cycle(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 19) == 0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/viterbi_ctrl.md
VITERBI_CTRL -- requirements
Module: viterbi_ctrl

Interface
REQ-001 Parameter: FRAME_LEN, default 256, trellis stages per frame; power of two, at least 4.
REQ-002 Parameter: ADDR_W, default $clog2(FRAME_LEN), survivor-memory address width.
REQ-003 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  in  1  received symbol pair offered.
REQ-006 Port: rx_pair  in  2  received code-bit pair.
REQ-007 Port: in_ready  out  1  controller accepts a symbol this cycle.
REQ-008 Port: rx_pair_q  out  2  registered copy of the accepted symbol, fed to the branch-metric units.
REQ-009 Port: acs_en  out  1  ACS stage enable.
REQ-010 Port: acs_init  out  1  first stage of the frame; ACS loads initial path metrics.
REQ-011 Port: mem_we  out  1  survivor-memory write enable.
REQ-012 Port: mem_addr  out  ADDR_W  survivor-memory address, used for both write and traceback read.
REQ-013 Port: tb_en  out  1  traceback unit enable.
REQ-014 Port: tb_start  out  1  first traceback cycle.
REQ-015 Port: frame_done  out  1  one-cycle pulse when the frame is complete.
REQ-016 Port: busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, ACS, FLUSH, TB, DONE.
REQ-018 in_ready is combinational: 1 in IDLE and ACS, 0 in all other states.
REQ-019 Accept occurs when in_valid and in_ready are both 1; a stage counter k (0..FRAME_LEN-1) counts accepts.
REQ-020 The cycle after accept k: acs_en=1, mem_we=1, mem_addr=k, rx_pair_q=accepted rx_pair, acs_init=(k==0).
REQ-021 A cycle without an accept produces acs_en=0 and mem_we=0 on the next cycle; k and rx_pair_q hold.
REQ-022 IDLE goes to ACS on accept k=0; ACS goes to FLUSH on accept k=FRAME_LEN-1; no other exits from ACS.
REQ-023 FLUSH lasts exactly 1 cycle and carries the final write; then the FSM enters TB.
REQ-024 TB lasts FRAME_LEN cycles with tb_en=1, mem_we=0, acs_en=0, and mem_addr descending FRAME_LEN-1 to 0.
REQ-025 tb_start=1 only on the TB cycle with mem_addr=FRAME_LEN-1.
REQ-026 After the TB cycle with mem_addr=0, the FSM enters DONE; DONE lasts 1 cycle with frame_done=1, then returns to IDLE.
REQ-027 The address counter wraps cleanly; the next frame starts again at k=0 with acs_init asserted.
REQ-028 All outputs except in_ready are registered.

Reset
REQ-029 While rst is high: state=IDLE, k=0, and acs_en, acs_init, mem_we, tb_en, tb_start, frame_done, busy, mem_addr, rx_pair_q are all 0.
REQ-030 rst mid-frame (ACS/FLUSH/TB) discards the frame; no frame_done is produced; the first accept after release is k=0.

Configuration
REQ-031 Macro VITERBI_CTRL_ABORT_EN defined adds the input port abort (1 bit, synchronous).
REQ-032 With VITERBI_CTRL_ABORT_EN, abort=1 forces in_ready=0 that cycle; the next cycle has state IDLE, k=0, all strobes 0, and no frame_done; abort takes precedence over every transition.
REQ-033 Without VITERBI_CTRL_ABORT_EN, there is no abort port and behaviour is REQ-017..REQ-030 unchanged.

Structure
REQ-034 Package viterbi_pkg holds the FSM state enum typedef and the FRAME_LEN default constant.
REQ-035 Sub-module viterbi_addr_cnt holds the up/down stage-address counter (load, increment, decrement, terminal-count flags); the FSM stays in viterbi_ctrl.

Verification
REQ-036 FRAME_LEN=4, in_valid=1 from cycle 0 -> accepts at cycles 0-3; acs_en/mem_we at cycles 1-4 with mem_addr 0,1,2,3; acs_init only at cycle 1; FLUSH at cycle 4.
REQ-037 Same run -> TB at cycles 5-8 with mem_addr 3,2,1,0 and tb_start at cycle 5; frame_done at cycle 9; in_ready=1 at cycle 10.
REQ-038 in_valid toggling 1,0,1,0 with FRAME_LEN=4 -> acs_en alternates; FLUSH follows the 4th accept; rx_pair_q tracks only accepted symbols.
REQ-039 rst asserted during TB (mem_addr=2) -> all outputs 0 asynchronously; no frame_done; next frame starts with acs_init=1 and mem_addr=0.
REQ-040 in_valid held 1 through DONE -> in_ready=0 in FLUSH, TB and DONE; no symbol lost or double-counted; back-to-back frames are correct.
REQ-041 VITERBI_CTRL_ABORT_EN, abort at accept k=2 -> that symbol not accepted; IDLE next cycle; no frame_done; the following frame is normal.
